// File: rtl/mem_resp_slave.sv
// mem_resp_slave: valid/ready memory responder with programmable access latency.
// Macro: MEM_RESP_RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles.
module mem_resp_slave #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // Sparse word store backing pmem_read/pmem_write.
  logic [31:0] mem [int unsigned];
  int unsigned read_cnt;
  int unsigned write_cnt;

  function automatic int pmem_read(input int raddr);
    int unsigned key;
    key = unsigned'(raddr) >> 2;
    read_cnt = read_cnt + 1;
    return mem.exists(key) ? mem[key] : '0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input int len);
    int unsigned key;
    int unsigned off;
    logic [31:0] word;
    key  = unsigned'(waddr) >> 2;
    off  = unsigned'(waddr) & 32'd3;
    word = mem.exists(key) ? mem[key] : '0;
    for (int unsigned i = 0; i < 4; i++)
      if (i < unsigned'(len) && off + i < 4)
        word[8*(off+i) +: 8] = wdata[8*i +: 8];
    mem[key]  = word;
    write_cnt = write_cnt + 1;
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [4:0]        cnt;
  logic [4:0]        cnt_load;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [31:0]       addr32;
  logic              accept;
  logic              done;
  logic              bad;

  assign accept = (state == IDLE) && req_valid;
  assign done   = (state == WAIT) && (cnt == '0);
  assign addr32 = 32'(cap_addr);

`ifdef MEM_RESP_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_load = 5'(LATENCY - 1) + 5'(lfsr[1:0]);
`else
  assign cnt_load = 5'(LATENCY - 1);
`endif

  always_comb begin
    case (cap_size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr32[0];
      2'd2:    bad = |addr32[1:0];
      default: bad = 1'b1;
    endcase
  end

  function automatic logic [31:0] load_fit(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return {24'b0, sh[7:0]};
      2'd1:    return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // The memory access lives only on the WAIT->RESP edge so a stalled response never repeats it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_size  <= req_size;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= cnt_load;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 5'd1;
      end
      if (done) begin
        if (bad) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else if (cap_we) begin
          pmem_write(int'(addr32), int'(cap_wdata),
                     int'({cap_size == 2'd2, cap_size == 2'd1, cap_size == 2'd0}));
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= load_fit(pmem_read(int'({addr32[31:2], 2'b00})), addr32[1:0], cap_size);
          rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule
